// File: rtl/bram_portb_reader_if.sv
// ----------------------------------------------------------------------------
// bram_portb_reader_if
// Bundles the BRAM port-B bus and the outgoing word stream of the port-B
// read-DMA engine.
//   web     : port-B byte write enables (reader drives all-zero)
//   addrb   : port-B word address
//   dinb    : port-B write data (reader drives zero)
//   doutb   : port-B read data, valid one cycle after addrb
//   m_valid : stream word valid
//   m_data  : stream word
//   m_last  : final word of the transfer
//   m_ready : downstream accept
// Modports: master = reader side, slave = BRAM + stream consumer side.
// ----------------------------------------------------------------------------
interface bram_portb_reader_if #(
  parameter int ADDR_W = 9
);
  logic [3:0]        web;
  logic [ADDR_W-1:0] addrb;
  logic [31:0]       dinb;
  logic [31:0]       doutb;
  logic              m_valid;
  logic [31:0]       m_data;
  logic              m_last;
  logic              m_ready;

  modport master (
    output web, addrb, dinb, m_valid, m_data, m_last,
    input  doutb, m_ready
  );

  modport slave (
    input  web, addrb, dinb, m_valid, m_data, m_last,
    output doutb, m_ready
  );
endinterface

// File: rtl/bram_portb_reader.sv
// ----------------------------------------------------------------------------
// bram_portb_reader
// Read-DMA engine on port B of the 32-bit x 512-word BRAM. A start strobe
// latches a base address and word count; consecutive words are read through
// port B and presented on a valid/ready stream, with m_last on the final
// word and a one-cycle done pulse once that word has been accepted.
// Ports:
//   Clk       : system clock (BRAM clkb is tied to the same clock)
//   Reset_n   : asynchronous active-low reset
//   start     : one-cycle command strobe, ignored while busy or in DONE
//   base_addr : first word address, sampled with start
//   word_cnt  : number of words 0..512, sampled with start
//   busy      : transfer in progress
//   done      : one-cycle completion pulse
//   bus       : port-B bus and output stream (master modport)
// ----------------------------------------------------------------------------
module bram_portb_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 9
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  output logic              busy,
  output logic              done,
  bram_portb_reader_if.master bus
);

  // The buffer is the output register (head word) plus a small ring holding
  // the remaining FIFO_DEPTH-1 words.
  localparam int RING_D = FIFO_DEPTH - 1;
  localparam int PTR_W  = (RING_D > 1) ? $clog2(RING_D) : 1;
  localparam int CNT_W  = $clog2(RING_D + 1);
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 3) + 1;
  localparam int WC_W   = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic [ADDR_W-1:0] addrb_r;
  logic [WC_W-1:0]   rem_r;       // reads still to issue after the current one

  // Read pipeline: p1 = address presented to BRAM, p2 = doutb valid now.
  logic              rd_p1_r, rd_p2_r;
  logic              last_p1_r, last_p2_r;

  logic              m_valid_r;
  logic [31:0]       m_data_r;
  logic              m_last_r;

  logic [32:0]       ring_r [RING_D];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  ring_cnt_r;

  logic              pop_s;
  logic              out_from_ring_s;
  logic              out_from_push_s;
  logic              ring_push_s;
  logic [LVL_W-1:0]  level_s;
  logic              can_issue_s;
  logic              issue_s;
  logic              issue_last_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RING_D - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Buffer steering: the head register refills from the ring first, and a
  // landing word bypasses the ring only when the ring is empty.
  always_comb begin
    pop_s           = m_valid_r & bus.m_ready;
    out_from_ring_s = 1'b0;
    out_from_push_s = 1'b0;
    if (!m_valid_r || pop_s) begin
      out_from_ring_s = (ring_cnt_r != '0);
      out_from_push_s = (ring_cnt_r == '0) && rd_p2_r;
    end else begin
      out_from_ring_s = 1'b0;
      out_from_push_s = 1'b0;
    end
    ring_push_s = rd_p2_r && !out_from_push_s;
  end

  // Issue decision: words buffered plus reads in flight, less the word
  // leaving this edge, must leave room for one more.
  always_comb begin
    level_s      = LVL_W'(ring_cnt_r) + LVL_W'(m_valid_r)
                 + LVL_W'(rd_p1_r) + LVL_W'(rd_p2_r);
    can_issue_s  = (level_s - LVL_W'(pop_s)) < LVL_W'(FIFO_DEPTH);
    issue_s      = 1'b0;
    issue_last_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && (word_cnt != '0)) begin
          issue_s      = 1'b1;
          issue_last_s = (word_cnt == WC_W'(1));
        end else begin
          issue_s      = 1'b0;
          issue_last_s = 1'b0;
        end
      end
      ST_READ: begin
        issue_s      = can_issue_s;
        issue_last_s = can_issue_s && (rem_r == WC_W'(1));
      end
      default: begin
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
      end
    endcase
  end

  // Control FSM: command capture, address generation, completion.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      addrb_r <= '0;
      rem_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (word_cnt == '0) begin
              done_r <= 1'b1;
            end else begin
              addrb_r <= base_addr;
              rem_r   <= word_cnt - WC_W'(1);
              busy_r  <= 1'b1;
              state_r <= issue_last_s ? ST_DRAIN : ST_READ;
            end
          end
        end
        ST_READ: begin
          if (issue_s) begin
            addrb_r <= addrb_r + ADDR_W'(1);   // natural wrap 1FF -> 000
            rem_r   <= rem_r - WC_W'(1);
            if (issue_last_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop_s && m_last_r) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Read pipeline tracking and head/ring bookkeeping.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_p1_r    <= 1'b0;
      rd_p2_r    <= 1'b0;
      last_p1_r  <= 1'b0;
      last_p2_r  <= 1'b0;
      m_valid_r  <= 1'b0;
      m_data_r   <= '0;
      m_last_r   <= 1'b0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      ring_cnt_r <= '0;
    end else begin
      rd_p1_r   <= issue_s;
      last_p1_r <= issue_last_s;
      rd_p2_r   <= rd_p1_r;
      last_p2_r <= last_p1_r;

      if (out_from_ring_s) begin
        m_valid_r <= 1'b1;
        m_data_r  <= ring_r[rd_ptr_r][31:0];
        m_last_r  <= ring_r[rd_ptr_r][32];
      end else if (out_from_push_s) begin
        m_valid_r <= 1'b1;
        m_data_r  <= bus.doutb;
        m_last_r  <= last_p2_r;
      end else if (pop_s) begin
        m_valid_r <= 1'b0;
        m_last_r  <= 1'b0;
      end

      if (ring_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (out_from_ring_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      ring_cnt_r <= ring_cnt_r + CNT_W'(ring_push_s) - CNT_W'(out_from_ring_s);
    end
  end

  // Ring storage: data words carry their last flag in bit 32.
  always_ff @(posedge Clk) begin
    if (ring_push_s) begin
      ring_r[wr_ptr_r] <= {last_p2_r, bus.doutb};
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign bus.addrb   = addrb_r;
  assign bus.web     = 4'b0000;
  assign bus.dinb    = 32'h0000_0000;
  assign bus.m_valid = m_valid_r;
  assign bus.m_data  = m_data_r;
  assign bus.m_last  = m_last_r;

endmodule

// File: tb/tb_bram_portb_reader.sv
// ----------------------------------------------------------------------------
// tb_bram_portb_reader
// Self-checking bench for bram_portb_reader: a BRAM model preloaded with
// mem[i] = A500_0000 + i, a table of transfers with hand-computed first/last
// words, a cycle-exact timing table for the basic read, and hand-written
// zero-count and mid-transfer reset sequences.
// ----------------------------------------------------------------------------
module tb_bram_portb_reader;

  logic       Clk;
  logic       Reset_n;
  logic       start;
  logic [8:0] base_addr;
  logic [9:0] word_cnt;
  logic       busy;
  logic       done;

  bram_portb_reader_if bus ();

  bram_portb_reader dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // BRAM port-B model: synchronous read, one cycle of latency.
  logic [31:0] mem [512];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hA500_0000 + 32'(i);
  end
  always @(posedge Clk) bus.doutb <= mem[bus.addrb];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Downstream ready: fixed level or the 1,0,0,1 pattern.
  logic       rdy_toggle = 1'b0;
  logic       rdy_fixed  = 1'b1;
  logic [3:0] rdy_pat    = 4'b1001;
  int         pat_i      = 0;
  always @(posedge Clk) begin
    #2;
    if (rdy_toggle) begin
      bus.m_ready = rdy_pat[pat_i];
      pat_i = (pat_i + 1) % 4;
    end else begin
      bus.m_ready = rdy_fixed;
      pat_i = 0;
    end
  end

  // Stream monitor, sampled on the falling edge.
  logic        mon_en = 1'b0;
  logic [31:0] got_d[$];
  logic        got_l[$];
  int          done_cnt;
  logic        busy_seen, valid_seen;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;
  int          occ;
  always @(negedge Clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.m_valid), 32'd1);
        chk("hold_data", bus.m_data, prev_d);
        chk("hold_last", 32'(bus.m_last), 32'(prev_l));
      end
      if (bus.m_valid && bus.m_ready) begin
        got_d.push_back(bus.m_data);
        got_l.push_back(bus.m_last);
      end
      if (done) done_cnt++;
      if (busy) busy_seen = 1'b1;
      if (bus.m_valid) valid_seen = 1'b1;
      occ = int'(dut.ring_cnt_r) + int'(dut.m_valid_r);
      n_chk++;
      if (occ > 4) begin
        n_fail++;
        $display("FAIL fifo_occupancy: got %0d, allowed at most 4", occ);
      end
      chk("web_zero", 32'(bus.web), 32'd0);
      chk("dinb_zero", bus.dinb, 32'd0);
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_d     = bus.m_data;
      prev_l     = bus.m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // One transfer; optional second start injected inj cycles in.
  task automatic run_xfer(input logic [8:0] b, input logic [9:0] c, input int inj,
                          input logic [31:0] exp_first, input logic [31:0] exp_last);
    logic [8:0]  addr_before;
    logic [8:0]  a;
    logic [31:0] e;
    int          limit;
    int          cyc;
    got_d.delete();
    got_l.delete();
    done_cnt    = 0;
    busy_seen   = 1'b0;
    valid_seen  = 1'b0;
    addr_before = bus.addrb;
    mon_en      = 1'b1;
    @(posedge Clk); #2;
    start = 1'b1; base_addr = b; word_cnt = c;
    @(posedge Clk); #2;
    start = 1'b0;
    limit = (int'(c) + 4) * 4 + 40;
    cyc   = 0;
    while (done_cnt == 0 && cyc < limit) begin
      if (inj > 0 && cyc == inj) begin
        start = 1'b1; base_addr = 9'h000; word_cnt = 10'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge Clk); #2;
      cyc++;
    end
    start = 1'b0;
    repeat (4) @(posedge Clk);
    #2;
    mon_en = 1'b0;
    chk("word_count", 32'(got_d.size()), 32'(c));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    for (int k = 0; k < got_d.size() && k < int'(c); k++) begin
      a = b + 9'(k);
      e = 32'hA500_0000 + {23'd0, a};
      chk("word_data", got_d[k], e);
      chk("word_last", 32'(got_l[k]), 32'(k == int'(c) - 1));
    end
    if (c == 10'd0) begin
      chk("zero_busy", 32'(busy_seen), 32'd0);
      chk("zero_valid", 32'(valid_seen), 32'd0);
      chk("zero_addrb", 32'(bus.addrb), 32'(addr_before));
    end else begin
      chk("busy_seen", 32'(busy_seen), 32'd1);
      if (got_d.size() > 0) begin
        chk("first_word", got_d[0], exp_first);
        chk("final_word", got_d[got_d.size() - 1], exp_last);
      end
    end
  endtask

  typedef struct {
    logic [8:0]  base;
    logic [9:0]  cnt;
    logic        toggle;
    int          inj;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  typedef struct {
    logic [8:0]  addr;
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        b;
    logic        dn;
  } trow_t;

  vec_t  vecs [7];
  trow_t trows [8];
  logic [8:0] addr_hold;

  initial begin
    vecs[0] = '{9'h010, 10'd4,   1'b0, 0, 32'hA500_0010, 32'hA500_0013};
    vecs[1] = '{9'h020, 10'd16,  1'b1, 0, 32'hA500_0020, 32'hA500_002F};
    vecs[2] = '{9'h1FE, 10'd4,   1'b0, 0, 32'hA500_01FE, 32'hA500_0001};
    vecs[3] = '{9'h100, 10'd512, 1'b0, 0, 32'hA500_0100, 32'hA500_00FF};
    vecs[4] = '{9'h040, 10'd8,   1'b0, 4, 32'hA500_0040, 32'hA500_0047};
    vecs[5] = '{9'h005, 10'd1,   1'b1, 0, 32'hA500_0005, 32'hA500_0005};
    vecs[6] = '{9'h000, 10'd0,   1'b0, 0, 32'h0,         32'h0};

    // State after rising edge k+1 of the basic read (base 0x010, cnt 4).
    trows[0] = '{9'h010, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0};
    trows[1] = '{9'h011, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0};
    trows[2] = '{9'h012, 1'b1, 32'hA500_0010, 1'b0, 1'b1, 1'b0};
    trows[3] = '{9'h013, 1'b1, 32'hA500_0011, 1'b0, 1'b1, 1'b0};
    trows[4] = '{9'h013, 1'b1, 32'hA500_0012, 1'b0, 1'b1, 1'b0};
    trows[5] = '{9'h013, 1'b1, 32'hA500_0013, 1'b1, 1'b1, 1'b0};
    trows[6] = '{9'h013, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
    trows[7] = '{9'h013, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0};

    Reset_n = 1'b1; start = 1'b0; base_addr = 9'h000; word_cnt = 10'd0;
    #1 Reset_n = 1'b0;
    @(posedge Clk); @(posedge Clk); #2;
    chk("rst_busy",    32'(busy),        32'd0);
    chk("rst_done",    32'(done),        32'd0);
    chk("rst_addrb",   32'(bus.addrb),   32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_last",  32'(bus.m_last),  32'd0);
    chk("rst_m_data",  bus.m_data,       32'd0);
    Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #2;

    // Cycle-exact basic read.
    start = 1'b1; base_addr = 9'h010; word_cnt = 10'd4;
    @(posedge Clk); #2;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(posedge Clk);
      @(negedge Clk);
      chk("seq_addrb",   32'(bus.addrb),   32'(trows[k].addr));
      chk("seq_m_valid", 32'(bus.m_valid), 32'(trows[k].v));
      chk("seq_busy",    32'(busy),        32'(trows[k].b));
      chk("seq_done",    32'(done),        32'(trows[k].dn));
      if (trows[k].v) begin
        chk("seq_m_data", bus.m_data,       trows[k].d);
        chk("seq_m_last", 32'(bus.m_last),  32'(trows[k].l));
      end
    end

    // Zero count: done one cycle after start, nothing else moves.
    @(posedge Clk); #2;
    addr_hold = bus.addrb;
    start = 1'b1; base_addr = 9'h055; word_cnt = 10'd0;
    @(posedge Clk); #2;
    start = 1'b0;
    @(negedge Clk);
    chk("zc_done",    32'(done),        32'd1);
    chk("zc_busy",    32'(busy),        32'd0);
    chk("zc_m_valid", 32'(bus.m_valid), 32'd0);
    chk("zc_addrb",   32'(bus.addrb),   32'(addr_hold));
    @(negedge Clk);
    chk("zc_done_end", 32'(done), 32'd0);

    // Table-driven transfers.
    for (int i = 0; i < 7; i++) begin
      rdy_toggle = vecs[i].toggle;
      rdy_fixed  = 1'b1;
      @(posedge Clk); #2;
      run_xfer(vecs[i].base, vecs[i].cnt, vecs[i].inj, vecs[i].exp_first, vecs[i].exp_last);
    end
    rdy_toggle = 1'b0;

    // Reset in the middle of a stalled transfer.
    rdy_fixed = 1'b0;
    @(posedge Clk); #2;
    @(posedge Clk); #2;
    start = 1'b1; base_addr = 9'h030; word_cnt = 10'd10;
    @(posedge Clk); #2;
    start = 1'b0;
    repeat (7) @(posedge Clk);
    #2;
    chk("stall_addrb",   32'(bus.addrb),   32'h033);
    chk("stall_m_valid", 32'(bus.m_valid), 32'd1);
    chk("stall_m_data",  bus.m_data,       32'hA500_0030);
    Reset_n = 1'b0;
    #1;
    chk("arst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("arst_busy",    32'(busy),        32'd0);
    chk("arst_done",    32'(done),        32'd0);
    chk("arst_addrb",   32'(bus.addrb),   32'd0);
    @(posedge Clk); #2;
    Reset_n   = 1'b1;
    rdy_fixed = 1'b1;
    @(posedge Clk); #2;
    run_xfer(9'h020, 10'd2, 0, 32'hA500_0020, 32'hA500_0021);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
